// File: rtl/counter_pkg.sv
// Shared encodings and sizing helper for the configurable counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold 0..prescale-1, never less than one.
    function automatic int prescale_width(input int prescale);
        int w;
        w = 1;
        for (int i = 1; i <= 9; i++) begin
            if ((32'sd1 << i) < prescale) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that completes a period.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_r;

    // Prescale phase register; clear restarts the period without a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r <= {PW{1'b0}};
        end else if (clear) begin
            pre_r <= {PW{1'b0}};
        end else if (en) begin
            pre_r <= (pre_r == LAST) ? {PW{1'b0}} : pre_r + PW'(1);
        end else begin
            pre_r <= pre_r;
        end
    end

    assign tick = (PRESCALE == 1) ? en : (en && (pre_r == LAST));

endmodule

// File: rtl/config_counter.sv
// Up/down counter with load, wrap-or-saturate bounds, terminal-count pulse and sticky overflow.
module config_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = (2 ** WIDTH) - 1,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "config_counter: WIDTH must be at least 1");
    end
    if ((MAX < 1) || (MAX > (2 ** WIDTH) - 1)) begin : g_bad_max
        $fatal(1, "config_counter: MAX must lie in 1..2**WIDTH-1");
    end
    if ((PRESCALE < 1) || (PRESCALE > 256)) begin : g_bad_prescale
        $fatal(1, "config_counter: PRESCALE must lie in 1..256");
    end

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

    logic             tick_s;
    logic [WIDTH-1:0] count_r, count_next_s;
    logic             tc_r, tc_next_s;
    logic             ovf_r, ovf_next_s;
    logic             boundary_s;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (load),
        .tick  (tick_s)
    );

    // Next-state logic: load overrides a step; direction is sampled on the step cycle only.
    always_comb begin
        count_next_s = count_r;
        boundary_s   = 1'b0;
        if (load) begin
            count_next_s = (load_value > MAX_V) ? MAX_V : load_value;
        end else if (tick_s) begin
            if (up == DIR_UP) begin
                if (count_r >= MAX_V) begin
                    boundary_s   = 1'b1;
                    count_next_s = (SATURATE == MODE_SAT) ? MAX_V : ZERO_V;
                end else begin
                    count_next_s = count_r + WIDTH'(1);
                end
            end else begin
                if (count_r == ZERO_V) begin
                    boundary_s   = 1'b1;
                    count_next_s = (SATURATE == MODE_SAT) ? ZERO_V : MAX_V;
                end else begin
                    count_next_s = count_r - WIDTH'(1);
                end
            end
        end else begin
            count_next_s = count_r;
        end
        tc_next_s = boundary_s;
        // A boundary crossing in the same cycle as clear_ovf keeps the flag set.
        if (boundary_s) begin
            ovf_next_s = 1'b1;
        end else if (clear_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Output and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_V;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            tc_r    <= tc_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    assign count    = count_r;
    assign tc       = tc_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_config_counter.sv
// Drives four differently configured counters with one stimulus stream and checks them against a model.
module tb_config_counter;

    typedef struct {
        int cnt;
        int pre;
        bit tc;
        bit ovf;
    } mst_t;

    localparam int NDUT = 4;
    localparam int PMAX [NDUT] = '{15, 9, 15, 15};
    localparam int PSAT [NDUT] = '{0, 0, 1, 0};
    localparam int PPRE [NDUT] = '{1, 1, 1, 3};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       clear_ovf = 1'b0;

    logic [3:0] cnt_s [NDUT];
    logic       tc_s  [NDUT];
    logic       ovf_s [NDUT];

    int   checks = 0;
    int   errors = 0;
    mst_t ms [NDUT];
    mst_t expq [$];

    always #5 clk = ~clk;

    config_counter #(.WIDTH(4), .MAX(15), .SATURATE(0), .PRESCALE(1)) u0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
        .clear_ovf(clear_ovf), .count(cnt_s[0]), .tc(tc_s[0]), .overflow(ovf_s[0]));
    config_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
        .clear_ovf(clear_ovf), .count(cnt_s[1]), .tc(tc_s[1]), .overflow(ovf_s[1]));
    config_counter #(.WIDTH(4), .MAX(15), .SATURATE(1), .PRESCALE(1)) u2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
        .clear_ovf(clear_ovf), .count(cnt_s[2]), .tc(tc_s[2]), .overflow(ovf_s[2]));
    config_counter #(.WIDTH(4), .MAX(15), .SATURATE(0), .PRESCALE(3)) u3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(load_value),
        .clear_ovf(clear_ovf), .count(cnt_s[3]), .tc(tc_s[3]), .overflow(ovf_s[3]));

    function automatic mst_t model(input mst_t s, input int mx, input int sat, input int ps,
                                   input bit rst, input bit e, input bit u, input bit ld,
                                   input int lv, input bit clr);
        mst_t n;
        bit   bnd;
        n     = s;
        n.tc  = 1'b0;
        bnd   = 1'b0;
        if (rst) begin
            n.cnt = 0; n.pre = 0; n.ovf = 1'b0;
            return n;
        end
        if (ld) begin
            n.cnt = (lv > mx) ? mx : lv;
            n.pre = 0;
        end else if (e) begin
            if (s.pre == ps - 1) begin
                n.pre = 0;
                if (u) begin
                    if (s.cnt == mx) begin bnd = 1'b1; n.cnt = sat ? mx : 0; end
                    else n.cnt = s.cnt + 1;
                end else begin
                    if (s.cnt == 0) begin bnd = 1'b1; n.cnt = sat ? 0 : mx; end
                    else n.cnt = s.cnt - 1;
                end
            end else begin
                n.pre = s.pre + 1;
            end
        end
        if (bnd) begin
            n.tc = 1'b1; n.ovf = 1'b1;
        end else if (clr) begin
            n.ovf = 1'b0;
        end
        return n;
    endfunction

    task automatic step(input bit rst, input bit e, input bit u, input bit ld,
                        input logic [3:0] lv, input bit clr);
        mst_t x;
        reset = rst; en = e; up = u; load = ld; load_value = lv; clear_ovf = clr;
        for (int i = 0; i < NDUT; i++) begin
            ms[i] = model(ms[i], PMAX[i], PSAT[i], PPRE[i], rst, e, u, ld, int'(lv), clr);
            expq.push_back(ms[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            x = expq.pop_front();
            checks++;
            assert (cnt_s[i] === 4'(x.cnt)) else begin
                errors++;
                $error("FAIL count u%0d observed %0d expected %0d", i, cnt_s[i], x.cnt);
            end
            checks++;
            assert (tc_s[i] === x.tc) else begin
                errors++;
                $error("FAIL tc u%0d observed %0b expected %0b", i, tc_s[i], x.tc);
            end
            checks++;
            assert (ovf_s[i] === x.ovf) else begin
                errors++;
                $error("FAIL overflow u%0d observed %0b expected %0b", i, ovf_s[i], x.ovf);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) ms[i] = '{0, 0, 1'b0, 1'b0};

        // Reset, then wrap up through 15 on the plain 4-bit counter.
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("reset_count", cnt_s[0], 4'd0);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("wrap15_count", cnt_s[0], 4'd0);
        chk("wrap15_tc", {3'd0, tc_s[0]}, 4'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("wrap15_tc_drop", {3'd0, tc_s[0]}, 4'd0);
        chk("wrap15_ovf_sticky", {3'd0, ovf_s[0]}, 4'd1);

        // Count down from 0 with MAX=9, then clear the sticky flag.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("down_first", cnt_s[1], 4'd9);
        chk("down_first_tc", {3'd0, tc_s[1]}, 4'd1);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("down_zero", cnt_s[1], 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("down_wrap9", cnt_s[1], 4'd9);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("clear_ovf", {3'd0, ovf_s[1]}, 4'd0);

        // Saturating counter held at its bounds.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd14, 1'b0);
        chk("sat_load14", cnt_s[2], 4'd14);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("sat_15_tc0", {tc_s[2], cnt_s[2][2:0]}, 4'd7);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("sat_hold15", cnt_s[2], 4'd15);
        chk("sat_tc_a", {3'd0, tc_s[2]}, 4'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("sat_tc_b", {3'd0, tc_s[2]}, 4'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("sat_hold0", cnt_s[2], 4'd0);

        // Prescale by 3, with an enable gap two cycles into a period.
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("pre3_wait", cnt_s[3], 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("pre3_step1", cnt_s[3], 4'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("pre3_gap_hold", cnt_s[3], 4'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("pre3_reenable", cnt_s[3], 4'd2);

        // Load clamps to MAX and suppresses the step; reset mid-count.
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
        chk("load_clamp", cnt_s[1], 4'd9);
        chk("load_no_tc", {3'd0, tc_s[1]}, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("reset_mid", {ovf_s[1], tc_s[1], cnt_s[1][1:0]}, 4'd0);
        chk("reset_mid_count", cnt_s[1], 4'd0);

        // Boundary step coincident with clear_ovf keeps overflow set.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("set_wins", {3'd0, ovf_s[0]}, 4'd1);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_counter.md
CONFIG_COUNTER -- requirements
Module: config_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count register width in bits, at least 1.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: terminal count value; legal range is 1..2**WIDTH-1; count range is 0..MAX.
REQ-003 SHALL have parameter SATURATE, default 0: 0 means wrap at the bounds, 1 means hold at the bounds.
REQ-004 SHALL have parameter PRESCALE, default 1: number of enabled cycles per count step; legal values are 1..256.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: count enable; advances the prescaler.
REQ-008 SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-009 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-010 SHALL have port load_value, input, WIDTH bits: value to load.
REQ-011 SHALL have port clear_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-012 SHALL have port count, output, WIDTH bits: registered count value.
REQ-013 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-014 SHALL have port overflow, output, 1 bit: sticky boundary-crossing flag.

Function
REQ-015 Priority per edge SHALL be: reset, then load, then step.
REQ-016 load SHALL set count to min(load_value, MAX) and clear the prescaler; no step or tc occurs that cycle, regardless of en.
REQ-017 Prescaler SHALL increment only when en=1; a step is taken when en=1 and prescaler=PRESCALE-1, and the prescaler then returns to 0.
REQ-018 With en=0, the prescaler and count SHALL hold; PRESCALE=1 SHALL step on every enabled cycle.
REQ-019 A step with up=1 SHALL give count+1 if count<MAX; at count=MAX it gives 0 (SATURATE=0) or MAX (SATURATE=1).
REQ-020 A step with up=0 SHALL give count-1 if count>0; at count=0 it gives MAX (SATURATE=0) or 0 (SATURATE=1).
REQ-021 A boundary step (up at MAX, or down at 0) SHALL drive tc=1 for exactly the cycle after that edge; tc is 0 otherwise, and repeated saturated boundary steps pulse tc each time.
REQ-022 A boundary step SHALL set overflow=1; overflow stays set until clear_ovf=1 or reset.
REQ-023 When clear_ovf coincides with a boundary step, overflow SHALL remain 1 (set wins).
REQ-024 Changing up mid-prescale SHALL NOT reset the prescaler; the direction is sampled on the step edge.
REQ-025 count SHALL never exceed MAX under any input sequence.
REQ-026 All outputs SHALL be registered with no combinational input-to-output path; count changes on the step edge and is visible the following cycle.

Reset
REQ-027 While reset=1 at a clock edge: count=0, tc=0, overflow=0, prescaler=0; all other inputs are ignored.
REQ-028 Reset asserted mid-count SHALL take effect at the next edge with no partial step; counting resumes from 0 a full PRESCALE after release.

Structure
REQ-029 A shared package/include counter_pkg SHALL hold the direction encodings (DIR_UP=1, DIR_DOWN=0), the mode constants (MODE_WRAP=0, MODE_SAT=1), and the prescaler-width function ceil(log2(PRESCALE)) with a minimum of 1.
REQ-030 The prescaler SHALL be one sub-module, counter_prescaler (ports: clk, reset, en, clear, tick), instantiated once; when PRESCALE=1, tick=en.
REQ-031 Parameter legality (per REQ-002 and REQ-004) SHALL be checked at elaboration with a fatal error.

Verification
REQ-032 The bench SHALL cover: WIDTH=4, MAX=15, PRESCALE=1, reset 1 for 1 cycle, en=1, up=1 -> count 0,1..15,0; tc high only in the cycle after the 15->0 edge; overflow=1 thereafter.
REQ-033 The bench SHALL cover: MAX=9, up=0 from 0 -> count 9,8..0,9; tc pulses after the 0->9 edge; clear_ovf=1 for one cycle drops overflow to 0.
REQ-034 The bench SHALL cover: SATURATE=1, MAX=15, load_value=14 then up steps -> count 14,15,15,15; tc pulses after each step at 15; down steps from 0 hold 0.
REQ-035 The bench SHALL cover: PRESCALE=3, en=1 -> count increments every 3rd cycle; en=0 for 2 cycles after 2 enabled cycles, then en=1 -> step on the 1st re-enabled cycle.
REQ-036 The bench SHALL cover: MAX=9, load=1 with load_value=12 and en=1 -> count=9, no tc; reset at count=7 -> count=0, tc=0, overflow=0 next cycle.
REQ-037 The bench SHALL cover: clear_ovf=1 on a boundary-step cycle -> overflow stays 1.
